// File: rtl/uart_tx_buf.sv
// uart_tx_buf: 8N1 UART transmitter fed by a small byte FIFO.
// Bytes queued with trmt are sent LSB first, each bit held BAUD_DIV clocks.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | line high; pops the FIFO head into the shift register
// SEND  | shifting a 10-bit frame {stop, data, start} out on TX
module uart_tx_buf #(
  parameter int BAUD_DIV   = 2604,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       TX,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  logic [0:0]    state_q, state_d;
  logic [9:0]    shift_q, shift_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          push, pop;

  logic [7:0] mem [FIFO_DEPTH];

  assign tx_full = (count_q == COUNT_FULL);
  assign tx_busy = (state_q == SEND) || (count_q != '0);
  assign TX      = tx_q;
  assign tx_done = done_q;

  // Next-state logic: FIFO bookkeeping, frame sequencing and line level.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    // A full FIFO drops the strobe even if a pop frees a slot this cycle.
    push    = trmt && !tx_full;

    case (state_q)
      IDLE: begin
        // bit_q==10 only in the first IDLE cycle after a stop bit, so the
        // done pulse lines up with the end of the stop bit on the TX flop.
        done_d = (bit_q == 4'd10);
        bit_d  = '0;
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = {1'b1, mem[rptr_q], 1'b0};
          state_d = SEND;
        end
      end
      SEND: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = {1'b1, shift_q[9:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    tx_d = (state_q == SEND) ? shift_q[0] : 1'b1;
  end

  // Control and datapath registers; reset aborts any frame and empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // FIFO storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: accepted bytes are queued as expected
// frames; a line monitor decodes TX and checks bytes, bit timing and tx_done.
module tb_uart_tx_buf;

  localparam int B     = 4;
  localparam int D     = 4;
  localparam int FRAME = 10 * B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       trmt = 1'b0;
  logic       TX, tx_full, tx_busy, tx_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frames_seen = 0;
  int dones_seen = 0;
  int last_end = 0;
  bit mon_busy = 1'b0;
  bit expect_b2b = 1'b0;
  logic [7:0] exp_q[$];

  uart_tx_buf #(.BAUD_DIV(B), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .trmt(trmt),
    .TX(TX), .tx_full(tx_full), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) if (tx_done === 1'b1) dones_seen++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe trmt for one edge; accepted bytes become expected frames.
  task automatic send(input logic [7:0] d, input bit accept);
    tx_data = d;
    trmt = 1'b1;
    @(posedge clk);
    #1 trmt = 1'b0;
    if (accept) exp_q.push_back(d);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((tx_busy !== 1'b0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tx_busy !== 1'b0 || mon_busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Line monitor: decodes every frame and compares against the scoreboard.
  initial begin : monitor
    logic [9:0] bits;
    logic [7:0] exp_b;
    int hold_err, done_err;
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1 || TX !== 1'b0) continue;
      mon_busy = 1'b1;
      aborted = 1'b0;
      hold_err = 0;
      done_err = 0;
      bits = '1;
      if (expect_b2b) check("frame_gap", cyc - last_end, 1);
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) @(negedge clk);
        if (rst_n !== 1'b1) begin
          aborted = 1'b1;
          break;
        end
        if (k % B == 0) bits[k / B] = TX;
        else if (TX !== bits[k / B]) hold_err++;
        if (tx_done !== 1'b0) done_err++;
      end
      if (aborted) begin
        expect_b2b = 1'b0;
        mon_busy = 1'b0;
        continue;
      end
      @(negedge clk);
      last_end = cyc;
      check("done_at_stop_end", tx_done, 1);
      check("line_high_after_stop", TX, 1);
      check("start_bit", bits[0], 0);
      check("stop_bit", bits[9], 1);
      check("bit_hold", hold_err, 0);
      check("done_inside_frame", done_err, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_byte: got %0h with nothing queued", bits[8:1]);
      end else begin
        exp_b = exp_q.pop_front();
        check("frame_byte", bits[8:1], exp_b);
      end
      frames_seen++;
      expect_b2b = (exp_q.size() > 0);
      mon_busy = 1'b0;
    end
  end

  initial begin : stim
    int dones_before;
    int n;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", TX, 1);
    check("reset_busy", tx_busy, 0);
    check("reset_full", tx_full, 0);
    check("reset_done", tx_done, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single byte: pop one edge after the push, TX falls the edge after that.
    send(8'hA5, 1'b1);
    check("busy_after_push", tx_busy, 1);
    check("tx_high_at_push", TX, 1);
    @(posedge clk);
    #1 check("tx_high_at_pop", TX, 1);
    @(posedge clk);
    #1 check("tx_fall_latency", TX, 0);
    wait_idle(FRAME + 20);
    check("frames_after_a5", frames_seen, 1);
    check("dones_after_a5", dones_seen, 1);

    // Burst of five: first goes straight to the shifter, four fill the FIFO.
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
    check("full_after_burst", tx_full, 1);
    send(8'hFF, 1'b0);
    check("full_after_drop", tx_full, 1);
    wait_idle(6 * FRAME + 40);
    check("frames_after_burst", frames_seen, 6);
    check("full_after_drain", tx_full, 0);

    // Push on the same edge as the IDLE pop with one entry queued.
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    check("busy_push_pop", tx_busy, 1);
    check("not_full_push_pop", tx_full, 0);
    wait_idle(3 * FRAME + 40);
    check("frames_after_pushpop", frames_seen, 8);

    // Reset during data bit 3 aborts the frame with no done pulse.
    dones_before = dones_seen;
    send(8'h96, 1'b1);
    n = 0;
    while (TX !== 1'b0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("fall_before_reset", TX, 0);
    repeat (4 * B + 1) @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("reset_mid_tx", TX, 1);
    check("reset_mid_busy", tx_busy, 0);
    check("reset_mid_done", tx_done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("no_done_on_abort", dones_seen, dones_before);
    send(8'h3C, 1'b1);
    wait_idle(FRAME + 20);
    check("frames_after_reset", frames_seen, 9);
    check("dones_after_reset", dones_seen, dones_before + 1);

    // All 256 byte values, queued as fast as the FIFO accepts them.
    for (int v = 0; v < 256; v++) begin
      n = 0;
      while (tx_full === 1'b1 && n < 2 * FRAME) begin
        @(posedge clk);
        #1;
        n++;
      end
      send(8'(v), 1'b1);
    end
    wait_idle(6 * FRAME + 40);

    check("frames_total", frames_seen, 265);
    check("dones_total", dones_seen, frames_seen);
    check("scoreboard_empty", exp_q.size(), 0);
    check("final_busy", tx_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
